// File: rtl/imem_loader_pkg.sv
// Shared constants and FSM state encoding for the instruction-memory loader.
// The instruction memory uses the same depth and address-width constants.
package imem_loader_pkg;
    localparam int IMEM_DEPTH = 128;
    localparam int IMEM_AW    = 7;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_DATA  = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4,
        S_ERROR = 3'd5
    } state_e;
endpackage

// File: rtl/imem_loader_if.sv
// Host byte stream, memory write port and status of the loader in one bundle.
// rx handshake: a byte moves on a rising edge where rx_valid and rx_ready are both 1.
interface imem_loader_if #(parameter int N = 32);
    import imem_loader_pkg::*;

    logic               start;
    logic               rx_valid;
    logic [7:0]         rx_data;
    logic               rx_ready;
    logic               we;
    logic [IMEM_AW-1:0] waddr;
    logic [N-1:0]       wdata;
    logic               busy;
    logic               done;
    logic               err;
    logic               cpu_hold;
    logic [2:0]         state;

    modport master (
        output start, rx_valid, rx_data,
        input  rx_ready, we, waddr, wdata, busy, done, err, cpu_hold, state
    );

    modport slave (
        input  start, rx_valid, rx_data,
        output rx_ready, we, waddr, wdata, busy, done, err, cpu_hold, state
    );
endinterface

// File: rtl/imem_loader_word_assembler.sv
// Packs a little-endian byte stream into N-bit words and emits a one-cycle
// write pulse with the finished word on the cycle after its last byte.
module word_assembler #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr_i,
    input  logic         byte_valid_i,
    input  logic [7:0]   byte_i,
    output logic         byte_last_o,
    output logic         we_o,
    output logic [N-1:0] wdata_o
);
    localparam int BPW = N / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  sh_q, sh_d;
    logic [N-1:0]  wdata_q, wdata_d;
    logic          we_q, we_d;
    logic [N-1:0]  shifted;

    // New byte enters at the top so the first byte of a word ends up in [7:0].
    assign shifted     = (sh_q >> 8) | (N'(byte_i) << (N - 8));
    assign byte_last_o = byte_valid_i && (cnt_q == CW'(BPW - 1));

    // The output word is a separate register so the next word can start
    // shifting in during the write pulse without disturbing wdata.
    always_comb begin
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        if (clr_i) begin
            cnt_d = '0;
        end else if (byte_valid_i) begin
            sh_d = shifted;
            if (byte_last_o) begin
                cnt_d   = '0;
                wdata_d = shifted;
                we_d    = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            sh_q    <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
        end
    end

    assign we_o    = we_q;
    assign wdata_o = wdata_q;
endmodule

// File: rtl/imem_loader.sv
// Loads a framed program (count, little-endian words, XOR checksum) from a byte
// stream into instruction memory and keeps the CPU in reset unless it checked out.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = IMEM_DEPTH
) (
    input  logic          clk,
    input  logic          reset,
    imem_loader_if.slave  bus
);
    localparam logic [2:0] IDLE  = S_IDLE;
    localparam logic [2:0] COUNT = S_COUNT;
    localparam logic [2:0] DATA  = S_DATA;
    localparam logic [2:0] CHECK = S_CHECK;
    localparam logic [2:0] DONE  = S_DONE;
    localparam logic [2:0] ERROR = S_ERROR;
    localparam logic [8:0] DEPTH_W = 9'(DEPTH);

    logic [2:0]         state_q, state_d;
    logic [7:0]         count_q, count_d;
    logic [7:0]         chk_q, chk_d;
    logic [IMEM_AW-1:0] widx_q, widx_d;
    logic [IMEM_AW-1:0] waddr_q, waddr_d;
    logic               in_frame, accept, start_ok, asm_byte;
    logic               byte_last, word_we;
    logic [N-1:0]       word_data;

    assign in_frame = (state_q == COUNT) || (state_q == DATA) || (state_q == CHECK);
    assign accept   = bus.rx_valid && in_frame;
    assign start_ok = bus.start && !in_frame;
    assign asm_byte = accept && (state_q == DATA);

    // widx counts words as their last byte arrives; waddr latches it alongside
    // the assembled word so the address is stable for the write pulse.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        chk_d   = chk_q;
        widx_d  = widx_q;
        waddr_d = waddr_q;
        case (state_q)
            IDLE, DONE, ERROR: begin
                if (bus.start) begin
                    state_d = COUNT;
                    widx_d  = '0;
                end
            end
            COUNT: begin
                if (accept) begin
                    if ((bus.rx_data == 8'd0) || ({1'b0, bus.rx_data} > DEPTH_W)) begin
                        state_d = ERROR;
                    end else begin
                        count_d = bus.rx_data;
                        chk_d   = bus.rx_data;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept) begin
                    chk_d = chk_q ^ bus.rx_data;
                    if (byte_last) begin
                        waddr_d = widx_q;
                        if ({1'b0, widx_q} == (count_q - 8'd1)) begin
                            state_d = CHECK;
                        end else begin
                            widx_d = widx_q + 1'b1;
                        end
                    end
                end
            end
            CHECK: begin
                if (accept) begin
                    state_d = (bus.rx_data == chk_q) ? DONE : ERROR;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            chk_q   <= '0;
            widx_q  <= '0;
            waddr_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            chk_q   <= chk_d;
            widx_q  <= widx_d;
            waddr_q <= waddr_d;
        end
    end

    word_assembler #(.N(N)) u_word_assembler (
        .clk          (clk),
        .reset        (reset),
        .clr_i        (start_ok),
        .byte_valid_i (asm_byte),
        .byte_i       (bus.rx_data),
        .byte_last_o  (byte_last),
        .we_o         (word_we),
        .wdata_o      (word_data)
    );

    assign bus.rx_ready = in_frame;
    assign bus.busy     = in_frame;
    assign bus.done     = (state_q == DONE);
    assign bus.err      = (state_q == ERROR);
    assign bus.cpu_hold = (state_q != DONE);
    assign bus.we       = word_we;
    assign bus.waddr    = waddr_q;
    assign bus.wdata    = word_data;
    assign bus.state    = state_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: frames are sent byte by byte and every write
// pulse is matched against an expected queue of {waddr, wdata}.
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    imem_loader_if #(.N(32)) bus ();

    imem_loader #(.N(32), .DEPTH(128)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [38:0] exp_q[$];
    logic [7:0]  tx_q[$];
    int          cyc = 0;
    int          last_we_cyc = 0;
    bit          spacing_en = 1'b0;
    bit          have_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Write-port scoreboard: every pulse must match the head of exp_q.
    always @(negedge clk) begin
        logic [38:0] got;
        logic [38:0] e;
        if (bus.we === 1'b1) begin
            got = {bus.waddr, bus.wdata};
            checks++;
            assert (exp_q.size() > 0) else begin
                errors++;
                $error("FAIL we_unexpected observed=%0h expected=none", got);
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("we_addr_data", {25'd0, got}, {25'd0, e});
            end
            if (spacing_en) begin
                if (have_last) chk("we_spacing", 64'(cyc - last_we_cyc), 64'd4);
                have_last   = 1'b1;
                last_we_cyc = cyc;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        while (bus.rx_ready !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("rx_ready_wait", {63'd0, bus.rx_ready}, 64'd1);
        @(posedge clk);
        #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_all();
        while (tx_q.size() > 0) send_byte(tx_q.pop_front());
    endtask

    task automatic check_status(input string tag, input logic b, input logic d, input logic e);
        chk({tag, "_busy"},     {63'd0, bus.busy},     {63'd0, b});
        chk({tag, "_rx_ready"}, {63'd0, bus.rx_ready}, {63'd0, b});
        chk({tag, "_done"},     {63'd0, bus.done},     {63'd0, d});
        chk({tag, "_err"},      {63'd0, bus.err},      {63'd0, e});
        chk({tag, "_cpu_hold"}, {63'd0, bus.cpu_hold}, {63'd0, ~d});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_we"},    {63'd0, bus.we},    64'd0);
        chk({tag, "_waddr"}, {57'd0, bus.waddr}, 64'd0);
        chk({tag, "_wdata"}, {32'd0, bus.wdata}, 64'd0);
        chk({tag, "_state"}, {61'd0, bus.state}, {61'd0, S_IDLE});
        check_status(tag, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        logic [7:0] x;
        logic [7:0] k8;
        logic [7:0] b0, b1, b2, b3;

        bus.start    = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        reset        = 1'b0;
        idle(3);
        check_reset_state("reset");
        reset = 1'b1;
        idle(1);

        // Single word frame.
        pulse_start();
        check_status("f1_start", 1'b1, 1'b0, 1'b0);
        exp_q.push_back({7'd0, 32'hF8000001});
        tx_q = '{8'h01, 8'h01, 8'h00, 8'h00, 8'hF8, 8'hF8};
        send_all();
        idle(2);
        chk("f1_writes_left", 64'(exp_q.size()), 64'd0);
        check_status("f1_end", 1'b0, 1'b1, 1'b0);

        // Two words; XOR of 02 and the eight data bytes is 81. Stall and a
        // stray start mid-frame must not disturb the load.
        pulse_start();
        check_status("f2_start", 1'b1, 1'b0, 1'b0);
        exp_q.push_back({7'd0, 32'hF8000001});
        exp_q.push_back({7'd1, 32'hF8008002});
        tx_q = '{8'h02, 8'h01, 8'h00, 8'h00, 8'hF8};
        send_all();
        idle(2);
        pulse_start();
        chk("f2_start_ignored", {61'd0, bus.state}, {61'd0, S_DATA});
        tx_q = '{8'h02, 8'h80, 8'h00, 8'hF8, 8'h81};
        send_all();
        idle(2);
        chk("f2_writes_left", 64'(exp_q.size()), 64'd0);
        check_status("f2_end", 1'b0, 1'b1, 1'b0);

        // Same words, bad checksum: writes stay, frame fails.
        pulse_start();
        exp_q.push_back({7'd0, 32'hF8000001});
        exp_q.push_back({7'd1, 32'hF8008002});
        tx_q = '{8'h02, 8'h01, 8'h00, 8'h00, 8'hF8, 8'h02, 8'h80, 8'h00, 8'hF8, 8'h00};
        send_all();
        idle(2);
        chk("f3_writes_left", 64'(exp_q.size()), 64'd0);
        check_status("f3_end", 1'b0, 1'b0, 1'b1);

        // Illegal counts 00 and 81 go straight to error without writes.
        pulse_start();
        check_status("f4_start", 1'b1, 1'b0, 1'b0);
        send_byte(8'h00);
        idle(2);
        check_status("f4_zero", 1'b0, 1'b0, 1'b1);
        pulse_start();
        send_byte(8'h81);
        idle(2);
        check_status("f4_over", 1'b0, 1'b0, 1'b1);

        // Full memory, one byte per cycle: writes every 4 cycles at 0..127.
        pulse_start();
        spacing_en = 1'b1;
        have_last  = 1'b0;
        tx_q.push_back(8'h80);
        x = 8'h80;
        for (int k = 0; k < 128; k++) begin
            k8 = 8'(k);
            b0 = k8;
            b1 = ~k8;
            b2 = k8 ^ 8'h5A;
            b3 = 8'hC3;
            tx_q.push_back(b0);
            tx_q.push_back(b1);
            tx_q.push_back(b2);
            tx_q.push_back(b3);
            x = x ^ b0 ^ b1 ^ b2 ^ b3;
            exp_q.push_back({k8[6:0], b3, b2, b1, b0});
        end
        tx_q.push_back(x);
        send_all();
        idle(2);
        spacing_en = 1'b0;
        chk("f5_writes_left", 64'(exp_q.size()), 64'd0);
        chk("f5_last_waddr", {57'd0, bus.waddr}, 64'd127);
        check_status("f5_end", 1'b0, 1'b1, 1'b0);

        // Reset after two data bytes aborts the frame; a fresh frame then loads.
        pulse_start();
        tx_q = '{8'h01, 8'h11, 8'h22};
        send_all();
        reset = 1'b0;
        #2;
        check_reset_state("f6_reset");
        idle(2);
        reset = 1'b1;
        idle(3);
        chk("f6_no_write", 64'(exp_q.size()), 64'd0);
        pulse_start();
        exp_q.push_back({7'd0, 32'hF8000001});
        tx_q = '{8'h01, 8'h01, 8'h00, 8'h00, 8'hF8, 8'hF8};
        send_all();
        idle(2);
        chk("f6_writes_left", 64'(exp_q.size()), 64'd0);
        check_status("f6_end", 1'b0, 1'b1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
